// File: rtl/commit_trace_buffer.sv
// commit_trace_buffer: arm/trigger-controlled capture of retired instructions into a FWFT ring buffer
module commit_trace_buffer #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 16,
  parameter int WRAP  = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [XLEN-1:0]            in_pc,
  input  logic [31:0]                in_instr,
  input  logic [XLEN-1:0]            in_wdata,
  input  logic                       in_regwrite,
  input  logic                       arm,
  input  logic                       stop,
  input  logic                       trig_en,
  input  logic [XLEN-1:0]            trig_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_pc,
  output logic [31:0]                out_instr,
  output logic [XLEN-1:0]            out_wdata,
  output logic                       out_regwrite,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       overflow,
  output logic [1:0]                 state
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int RW = 2 * XLEN + 33;
  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;
  state_t         st;
  logic [AW-1:0]  wp, rp;
  logic [CW-1:0]  cnt, cap;
  logic [RW-1:0]  mem [DEPTH];
  logic           hit, push, pop, ovw, last;
  always_comb begin
    hit  = in_valid && in_pc == trig_pc;
    push = !arm && in_valid && (st == CAPTURE || (st == ARMED && hit));
    pop  = !arm && out_valid && out_ready;
    ovw  = WRAP != 0 && push && full && !pop;
    last = WRAP == 0 && push && cap == CW'(DEPTH - 1);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st       <= IDLE;
      wp       <= '0;
      rp       <= '0;
      cnt      <= '0;
      cap      <= '0;
      overflow <= 1'b0;
    end else if (arm) begin
      st       <= trig_en ? ARMED : CAPTURE;
      wp       <= '0;
      rp       <= '0;
      cnt      <= '0;
      cap      <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop || ovw) rp <= rp + AW'(1);
      if (push && !pop && !ovw) cnt <= cnt + CW'(1);
      else if (pop && !push) cnt <= cnt - CW'(1);
      if (push) cap <= cap + CW'(1);
      if (ovw) overflow <= 1'b1;
      if (((st == ARMED || st == CAPTURE) && stop) || last) st <= DONE;
      else if (st == ARMED && push) st <= CAPTURE;
    end
  end
  // storage is left unreset; its contents are only observed while count != 0
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= {in_pc, in_instr, in_wdata, in_regwrite};
  end
  assign {out_pc, out_instr, out_wdata, out_regwrite} = mem[rp];
  assign out_valid = cnt != '0;
  assign full      = cnt == CW'(DEPTH);
  assign count     = cnt;
  assign state     = st;
endmodule

// File: doc/commit_trace_buffer.md
COMMIT_TRACE_BUFFER -- requirements
Module: commit_trace_buffer

Interface
REQ-001 SHALL provide parameter XLEN, default 32, width of PC and write-back data.
REQ-002 SHALL provide parameter DEPTH, default 16, record capacity, power of two, >=2.
REQ-003 SHALL provide parameter WRAP, default 0: 0 = stop-when-full mode, 1 = circular overwrite mode.
REQ-004 SHALL provide ports:
  clk  in  1  sole clock, rising edge.
  rst  in  1  asynchronous, active-low reset.
  in_valid  in  1  one instruction retired this cycle.
  in_pc  in  XLEN  retired PC.
  in_instr  in  32  retired instruction word.
  in_wdata  in  XLEN  register-file write data.
  in_regwrite  in  1  RegWrite of retired instruction.
  arm  in  1  single-cycle start pulse.
  stop  in  1  single-cycle end-capture pulse.
  trig_en  in  1  1 = wait for trigger PC before capturing.
  trig_pc  in  XLEN  trigger PC.
  out_valid  out  1  record available at read port.
  out_ready  in  1  consumer accepts record.
  out_pc / out_instr / out_wdata / out_regwrite  out  XLEN/32/XLEN/1  oldest stored record.
  count  out  clog2(DEPTH)+1  records held.
  full  out  1  count == DEPTH.
  overflow  out  1  sticky: a record was overwritten.
  state  out  2  IDLE=0, ARMED=1, CAPTURE=2, DONE=3.

Function
REQ-005 SHALL implement FSM states IDLE, ARMED, CAPTURE, DONE.
REQ-006 arm in any state SHALL clear count, read/write pointers, capture counter and overflow, then enter ARMED if trig_en=1, else CAPTURE; arm SHALL take priority over any same-cycle push, pop or stop.
REQ-007 In ARMED, in_valid with in_pc == trig_pc SHALL store that record and enter CAPTURE; non-matching commits SHALL be ignored.
REQ-008 In CAPTURE, each in_valid cycle SHALL push one record {in_pc, in_instr, in_wdata, in_regwrite}.
REQ-009 WRAP=0: capture counter SHALL count pushes since arm (trigger record included); the push that makes it DEPTH SHALL enter DONE; commits in DONE or IDLE SHALL be dropped.
REQ-010 WRAP=1: push while full with no pop SHALL overwrite the oldest record, advance read pointer, hold count at DEPTH and set overflow; state stays CAPTURE.
REQ-011 stop in ARMED or CAPTURE SHALL enter DONE; a same-cycle commit SHALL still be captured.
REQ-012 out_valid SHALL equal (count != 0); read data SHALL be combinational from read pointer (first-word fall-through).
REQ-013 Pop SHALL occur when out_valid && out_ready, in any state, advancing read pointer by one.
REQ-014 Push and pop in the same cycle SHALL leave count unchanged; when full in WRAP=1 this is a normal push+pop, no overflow.
REQ-015 Pop with count==0 SHALL have no effect; pointers SHALL wrap modulo DEPTH.
REQ-016 count, full, overflow, state SHALL update on the clock edge following the causing event (one-cycle latency).

Reset
REQ-017 rst low SHALL immediately force state=IDLE, count=0, pointers=0, capture counter=0, overflow=0, full=0, out_valid=0, without waiting for clk.
REQ-018 Storage array contents need not be reset; out_pc/out_instr/out_wdata/out_regwrite are don't-care while out_valid=0.
REQ-019 Reset asserted mid-capture SHALL discard all records; first action after release SHALL require arm.

Verification
REQ-020 Reset release, no arm, 10 commits -> count=0, state=IDLE, out_valid=0.
REQ-021 DEPTH=4, WRAP=0, trig_en=0, arm, 6 commits PC 0x0,0x4..0x14, out_ready=0 -> count=4, state=DONE after 4th, read-out yields PCs 0x0,0x4,0x8,0xC, overflow=0.
REQ-022 trig_en=1, trig_pc=0x10, commits PC 0x0..0x1C step 4 -> first record out_pc=0x10, state ARMED until the 0x10 commit.
REQ-023 DEPTH=4, WRAP=1, 6 commits PC 0x0..0x14, out_ready=0 -> count=4, overflow=1, read-out 0x8,0xC,0x10,0x14.
REQ-024 WRAP=1, full, push and pop same cycle -> count stays 4, overflow stays 0, popped record is oldest.
REQ-025 rst low mid-CAPTURE with count=3 -> count=0, state=IDLE before next clk edge; arm then commit PC 0x40 -> out_pc=0x40, count=1.
